weight_stream_reader: RTL
=========================

WEIGHT_STREAM_READER -- requirements
Module: weight_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, weight word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, weight memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 28, number of weights per layer slice; DEPTH SHALL be in 1..2^ADDR_W.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 START  in  1  single-cycle request to stream all DEPTH weights; ignored unless IDLE.
REQ-007 BUSY  out  1  high in any state other than IDLE.
REQ-008 DONE  out  1  one-cycle pulse after the last word handshakes.
REQ-009 MEM_ADDR  out  ADDR_W  weight memory address.
REQ-010 MEM_EN  out  1  weight memory enable.
REQ-011 MEM_WE  out  1  weight memory write enable; constant 0.
REQ-012 MEM_DO  in  DATA_W  weight memory read data; updated on falling CLK edge when MEM_EN=1.
REQ-013 W_DATA  out  DATA_W  streamed weight.
REQ-014 W_VALID  out  1  W_DATA valid.
REQ-015 W_READY  in  1  consumer accepts; transfer when W_VALID and W_READY both high at a rising edge.
REQ-016 W_LAST  out  1  high with the word at address DEPTH-1.

Function
REQ-017 States SHALL be IDLE, FETCH, DRAIN; IDLE->FETCH on START; FETCH->DRAIN when address DEPTH-1 has been issued; DRAIN->IDLE on the handshake of the W_LAST word, with DONE asserted the following cycle.
REQ-018 MEM_EN and MEM_ADDR SHALL be combinational from registered state: MEM_EN=1 in FETCH when occ+pend-pop < 2, where occ = buffer occupancy (0..2), pend = read issued the previous cycle, pop = W_VALID and W_READY.
REQ-019 MEM_ADDR SHALL equal the read pointer; the pointer resets to 0 on START and increments by 1 per issued read, never exceeding DEPTH-1.
REQ-020 Data for a read issued in cycle N SHALL be written into the 2-entry output buffer at the rising edge ending cycle N+1, sampled from MEM_DO.
REQ-021 W_VALID SHALL be high whenever the buffer is non-empty; W_DATA/W_LAST SHALL present the buffer head and SHALL NOT change while W_VALID=1 and W_READY=0.
REQ-022 First W_VALID SHALL rise 2 cycles after the edge that samples START; with W_READY held 1, one word SHALL transfer per cycle, DEPTH words in DEPTH consecutive cycles.
REQ-023 The buffer SHALL never overflow; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-024 Words SHALL be emitted in address order 0..DEPTH-1 with no loss or duplication under arbitrary W_READY patterns.
REQ-025 START while BUSY=1 SHALL be ignored; START in the DONE-pulse cycle (state IDLE) SHALL be accepted.
REQ-026 DEPTH=1 SHALL emit a single word with W_LAST=1.

Reset
REQ-027 On RST=1 at a rising edge: state IDLE, pointer 0, buffer empty, pend 0; BUSY, DONE, W_VALID, W_LAST, MEM_EN SHALL be 0 and W_DATA, MEM_ADDR SHALL be 0.
REQ-028 RST SHALL take priority over START and over any in-flight read; the in-flight read result SHALL be discarded.

Configuration
REQ-029 Macro WEIGHT_STREAM_ABORT_EN, when defined, SHALL add input ABORT (1 bit): ABORT=1 at a rising edge in FETCH or DRAIN SHALL flush the buffer, drop any pending read, return to IDLE next cycle with no DONE pulse; ABORT SHALL have priority below RST and above START.
REQ-030 Without WEIGHT_STREAM_ABORT_EN, the ABORT port SHALL not exist and behaviour is as REQ-017..026.

Verification
REQ-031 Memory preloaded w[i]=16'h0100+i, DEPTH=28, W_READY=1, START pulse -> W_VALID 2 cycles later, 28 consecutive words 0x0100..0x011B, W_LAST on 0x011B, DONE one cycle after.
REQ-032 Same preload, W_READY toggling 1,0,0,1 repeatedly -> identical 28-word sequence, W_DATA stable during stalls, MEM_EN never issued with occ+pend-pop >= 2.
REQ-033 W_READY=0 for 10 cycles after START -> exactly 2 reads issued (addr 0,1), then MEM_EN=0 until W_READY rises; stream resumes at 0x0100.
REQ-034 RST asserted in cycle 5 of streaming -> next cycle all outputs at reset values; new START streams from address 0.
REQ-035 START pulsed while BUSY and again in the DONE cycle -> first ignored, second begins a new 28-word stream.
REQ-036 With WEIGHT_STREAM_ABORT_EN, ABORT at word 10 -> IDLE next cycle, W_VALID=0, no DONE; following START streams from 0x0100.

Source files
------------

// File: rtl/weight_stream_reader.sv
// weight_stream_reader
//   Streams DEPTH consecutive weight words, address 0..DEPTH-1, from a
//   synchronous weight memory to a valid/ready consumer through a 2-entry
//   output buffer.
//
// Parameters
//   DATA_W  weight word width
//   ADDR_W  weight memory address width
//   DEPTH   weights per layer slice, 1..2**ADDR_W
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   RST       synchronous active-high reset
//   START     one-cycle request to stream a slice; only honoured in IDLE
//   BUSY      high whenever not IDLE
//   DONE      one-cycle pulse following the handshake of the last word
//   MEM_ADDR  memory read address (the read pointer)
//   MEM_EN    memory read enable
//   MEM_WE    memory write enable, tied low
//   MEM_DO    memory read data, valid the cycle after a read is issued
//   W_DATA    streamed weight (buffer head)
//   W_VALID   buffer non-empty
//   W_READY   consumer accepts the head word
//   W_LAST    head word is from address DEPTH-1
//   ABORT     (only with WEIGHT_STREAM_ABORT_EN defined) flush and return
//             to IDLE without a DONE pulse
//
// Configuration macro: WEIGHT_STREAM_ABORT_EN
module weight_stream_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 28
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
`ifdef WEIGHT_STREAM_ABORT_EN
  input  logic              ABORT,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_EN,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic              pend_last_q, pend_last_d;
  logic [1:0]        occ_q, occ_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];

  logic              abort_w;
  logic              pop;
  logic              head_last;
  logic [2:0]        level;
  logic              issue;

`ifdef WEIGHT_STREAM_ABORT_EN
  assign abort_w = ABORT && (state_q != IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign pop       = (occ_q != 2'd0) && W_READY;
  assign head_last = last_q[rd_q];
  // Occupancy the buffer will have once the in-flight read lands and this
  // cycle's pop is taken; a new read may only be issued if that leaves room.
  assign level     = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue     = (state_q == FETCH) && (level < 3'd2);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_d      = issue;
    pend_last_d = issue && (ptr_q == LAST_ADDR);
    occ_d       = occ_q + {1'b0, pend_q} - {1'b0, pop};
    rd_d        = pop ? ~rd_q : rd_q;
    wr_d        = pend_q ? ~wr_q : wr_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FETCH;
          ptr_d   = '0;
        end
      end
      FETCH: begin
        if (issue) begin
          if (ptr_q == LAST_ADDR) state_d = DRAIN;
          else                    ptr_d   = ptr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_w) begin
      state_d     = IDLE;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      occ_d       = '0;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      occ_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      occ_q       <= occ_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      if (pend_q) begin
        data_q[wr_q] <= MEM_DO;
        last_q[wr_q] <= pend_last_q;
      end
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign MEM_ADDR = ptr_q;
  assign MEM_EN   = issue;
  assign MEM_WE   = 1'b0;
  assign W_VALID  = (occ_q != 2'd0);
  assign W_DATA   = data_q[rd_q];
  assign W_LAST   = W_VALID && head_last;

endmodule
